// File: rtl/mem_access_controller_if.sv
// Request/response and BRAM-port bundle for mem_access_controller.
// slave: the controller side; master: requesters plus the BRAM model.
interface mem_access_controller_if #(
    parameter int ADDR_W = 12
);
    logic              cpu_req;
    logic [31:0]       cpu_addr;
    logic [2:0]        cpu_LdStCtrl;
    logic [31:0]       cpu_wdata;
    logic              cpu_done;
    logic              cpu_err;
    logic [31:0]       cpu_rdata;
    logic              ldr_req;
    logic [31:0]       ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_done;
    logic [ADDR_W-1:0] mem_adr;
    logic [31:0]       mem_din;
    logic [3:0]        we_i;
    logic [3:0]        we_d;
    logic [31:0]       mem_dout;

    modport slave (
        input  cpu_req, cpu_addr, cpu_LdStCtrl, cpu_wdata,
        output cpu_done, cpu_err, cpu_rdata,
        input  ldr_req, ldr_addr, ldr_wdata,
        output ldr_done,
        output mem_adr, mem_din, we_i, we_d,
        input  mem_dout
    );

    modport master (
        output cpu_req, cpu_addr, cpu_LdStCtrl, cpu_wdata,
        input  cpu_done, cpu_err, cpu_rdata,
        output ldr_req, ldr_addr, ldr_wdata,
        input  ldr_done,
        input  mem_adr, mem_din, we_i, we_d,
        output mem_dout
    );
endinterface

// File: rtl/mem_access_controller.sv
// Sequences CPU loads/stores and loader word writes onto one shared
// synchronous-read BRAM port (imem + dmem), with loader starvation guard.
module mem_access_controller #(
    parameter int ADDR_W   = 12,
    parameter int MAX_WAIT = 8
) (
    input logic                    Clock,
    input logic                    Reset_n,
    mem_access_controller_if.slave bus
);
    localparam int               CNT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_is_load, r_is_ldr;
    logic [2:0]        r_ctrl;
    logic [1:0]        r_off;
    logic [ADDR_W-1:0] r_mem_adr;
    logic [31:0]       r_mem_din, r_rdata;
    logic [3:0]        r_we_i, r_we_d;
    logic              w_ldr_win, w_cpu_win, w_misalign, w_cpu_load, w_unused_addr;
    logic [3:0]        w_lanes;

    function automatic logic f_misaligned(input logic [2:0] ctl, input logic [1:0] off);
        logic v_half, v_word;
        v_half = (ctl == 3'd1) || (ctl == 3'd4) || (ctl == 3'd6);
        v_word = (ctl == 3'd2) || (ctl == 3'd7);
        return (v_half && off[0]) || (v_word && (off != 2'b00));
    endfunction

    function automatic logic [3:0] f_lanes(input logic [2:0] ctl, input logic [1:0] off);
        case (ctl)
            3'd5:    return 4'b1000 >> off;
            3'd6:    return off[1] ? 4'b0011 : 4'b1100;
            3'd7:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] f_store_data(input logic [2:0] ctl, input logic [31:0] rt);
        case (ctl)
            3'd5:    return {4{rt[7:0]}};
            3'd6:    return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

    // Big-endian extraction: byte offset 0 lives in bits 31:24.
    function automatic logic [31:0] f_extract(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] ctl);
        logic signed [7:0]  v_b;
        logic signed [15:0] v_h;
        case (off)
            2'd0:    v_b = word[31:24];
            2'd1:    v_b = word[23:16];
            2'd2:    v_b = word[15:8];
            default: v_b = word[7:0];
        endcase
        v_h = off[1] ? word[15:0] : word[31:16];
        case (ctl)
            3'd0:    return 32'(v_b);
            3'd1:    return 32'(v_h);
            3'd3:    return {24'b0, v_b};
            3'd4:    return {16'b0, v_h};
            default: return word;
        endcase
    endfunction

    assign w_ldr_win     = bus.ldr_req && (!bus.cpu_req || (r_wait_cnt == MAX_CNT));
    assign w_cpu_win     = bus.cpu_req && !w_ldr_win;
    assign w_cpu_load    = (bus.cpu_LdStCtrl <= 3'd4);
    assign w_misalign    = f_misaligned(bus.cpu_LdStCtrl, bus.cpu_addr[1:0]);
    assign w_lanes       = f_lanes(bus.cpu_LdStCtrl, bus.cpu_addr[1:0]);
    assign w_unused_addr = ^{bus.cpu_addr, bus.ldr_addr};

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_IDLE: begin
                if (w_ldr_win)      w_next = S_ISSUE;
                else if (w_cpu_win) w_next = w_misalign ? S_ERR : S_ISSUE;
                else                w_next = S_IDLE;
            end
            S_ISSUE: w_next = r_is_load ? S_WAIT : S_IDLE;
            S_WAIT:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Port registers are loaded only on the grant edge, so they are zero outside ISSUE.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wait_cnt <= '0;
            r_is_load  <= 1'b0;
            r_is_ldr   <= 1'b0;
            r_ctrl     <= '0;
            r_off      <= '0;
            r_mem_adr  <= '0;
            r_mem_din  <= '0;
            r_we_i     <= '0;
            r_we_d     <= '0;
            r_rdata    <= '0;
        end else begin
            r_mem_adr <= '0;
            r_mem_din <= '0;
            r_we_i    <= '0;
            r_we_d    <= '0;
            if (r_state == S_IDLE) begin
                if (w_ldr_win) begin
                    r_wait_cnt <= '0;
                    r_is_ldr   <= 1'b1;
                    r_is_load  <= 1'b0;
                    r_mem_adr  <= bus.ldr_addr[ADDR_W+1:2];
                    r_mem_din  <= bus.ldr_wdata;
                    r_we_i     <= {4{bus.ldr_addr[29]}};
                    r_we_d     <= {4{bus.ldr_addr[28]}};
                end else if (w_cpu_win) begin
                    if (bus.ldr_req && (r_wait_cnt != MAX_CNT))
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    r_is_ldr  <= 1'b0;
                    r_is_load <= w_cpu_load;
                    r_ctrl    <= bus.cpu_LdStCtrl;
                    r_off     <= bus.cpu_addr[1:0];
                    if (!w_misalign) begin
                        r_mem_adr <= bus.cpu_addr[ADDR_W+1:2];
                        if (!w_cpu_load) begin
                            r_mem_din <= f_store_data(bus.cpu_LdStCtrl, bus.cpu_wdata);
                            r_we_i    <= w_lanes & {4{bus.cpu_addr[29]}};
                            r_we_d    <= w_lanes & {4{bus.cpu_addr[28]}};
                        end
                    end
                end
            end
            if (r_state == S_WAIT)
                r_rdata <= f_extract(bus.mem_dout, r_off, r_ctrl);
        end
    end

    always_comb begin
        bus.cpu_done = ((r_state == S_ISSUE) && !r_is_ldr && !r_is_load) ||
                       (r_state == S_DONE) || (r_state == S_ERR);
        bus.cpu_err  = (r_state == S_ERR);
        bus.ldr_done = (r_state == S_ISSUE) && r_is_ldr;
    end

    assign bus.cpu_rdata = r_rdata;
    assign bus.mem_adr   = r_mem_adr;
    assign bus.mem_din   = r_mem_din;
    assign bus.we_i      = r_we_i;
    assign bus.we_d      = r_we_d;
endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: transaction-level reference model with a
// per-cycle compare process, directed literal cases, then random traffic.
module tb_mem_access_controller;
    localparam int ADDR_W   = 12;
    localparam int MAX_WAIT = 8;
    localparam int DEPTH    = 1 << ADDR_W;

    logic Clock   = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clock = ~Clock;

    mem_access_controller_if #(.ADDR_W(ADDR_W)) bus ();

    mem_access_controller #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // BRAM behind the port: synchronous read, byte-lane writes (dmem only is readable).
    logic [31:0] bram [DEPTH];
    always @(posedge Clock) begin
        bus.mem_dout <= bram[bus.mem_adr];
        for (int k = 0; k < 4; k++)
            if (bus.we_d[k]) bram[bus.mem_adr][8*k +: 8] <= bus.mem_din[8*k +: 8];
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [DEPTH];

    function automatic int op_size(input logic [2:0] ctl);
        case (ctl)
            3'd0, 3'd3, 3'd5: return 1;
            3'd1, 3'd4, 3'd6: return 2;
            default:          return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] ctl,
                                             input logic [1:0] off);
        int size, first;
        logic [31:0] v;
        size  = op_size(ctl);
        first = int'(off) & ~(size - 1);
        v = (w << (8 * first)) >> (8 * (4 - size));
        if (ctl == 3'd0 && v[7])  v = v | 32'hffffff00;
        if (ctl == 3'd1 && v[15]) v = v | 32'hffff0000;
        return v;
    endfunction

    function automatic void ref_store(input logic [2:0] ctl, input logic [1:0] off,
                                      input logic [31:0] rt, output logic [3:0] lanes,
                                      output logic [31:0] din);
        int size, first;
        size  = op_size(ctl);
        first = int'(off) & ~(size - 1);
        lanes = '0;
        din   = '0;
        for (int o = 0; o < 4; o++) begin
            din[8*(3-o) +: 8] = rt[8*(size-1-(o % size)) +: 8];
            if (o >= first && o < first + size) lanes[3-o] = 1'b1;
        end
    endfunction

    // Expected outputs per future cycle, kept in a small ring.
    logic [ADDR_W-1:0] e_adr [8];
    logic [31:0]       e_din [8];
    logic [3:0]        e_wi  [8];
    logic [3:0]        e_wd  [8];
    logic              e_cd  [8];
    logic              e_ce  [8];
    logic              e_ld  [8];
    logic              e_rs  [8];
    logic [31:0]       e_rv  [8];

    function automatic void clr_slot(input int s);
        e_adr[s] = '0; e_din[s] = '0; e_wi[s] = '0; e_wd[s] = '0;
        e_cd[s] = 1'b0; e_ce[s] = 1'b0; e_ld[s] = 1'b0; e_rs[s] = 1'b0; e_rv[s] = '0;
    endfunction

    int          cyc = 0, free_at = 0, wcnt = 0, m_s, m_n, m_w;
    logic [31:0] hold = '0, m_a, m_rt, m_din;
    logic [3:0]  m_lanes;
    logic [2:0]  m_ctl;

    initial for (int s = 0; s < 8; s++) clr_slot(s);

    always @(negedge Clock) begin
        if (!Reset_n) begin
            chk("rst_rdata", bus.cpu_rdata, 32'h0);
            chk("rst_ctl", 32'({bus.cpu_done, bus.cpu_err, bus.ldr_done, bus.we_i, bus.we_d}), 32'h0);
            chk("rst_adr", 32'(bus.mem_adr), 32'h0);
            chk("rst_din", bus.mem_din, 32'h0);
            for (int s = 0; s < 8; s++) clr_slot(s);
            hold = '0; wcnt = 0; free_at = 0;
        end else begin
            m_s = cyc % 8;
            if (e_rs[m_s]) hold = e_rv[m_s];
            chk("mem_adr", 32'(bus.mem_adr), 32'(e_adr[m_s]));
            chk("mem_din", bus.mem_din, e_din[m_s]);
            chk("we_i", 32'(bus.we_i), 32'(e_wi[m_s]));
            chk("we_d", 32'(bus.we_d), 32'(e_wd[m_s]));
            chk("cpu_done", 32'(bus.cpu_done), 32'(e_cd[m_s]));
            chk("cpu_err", 32'(bus.cpu_err), 32'(e_ce[m_s]));
            chk("ldr_done", 32'(bus.ldr_done), 32'(e_ld[m_s]));
            chk("cpu_rdata", bus.cpu_rdata, hold);
            clr_slot(m_s);
            if (cyc >= free_at) begin
                m_n = (cyc + 1) % 8;
                if (bus.ldr_req && (!bus.cpu_req || wcnt == MAX_WAIT)) begin
                    wcnt = 0;
                    m_a  = bus.ldr_addr;
                    m_w  = int'(m_a[ADDR_W+1:2]);
                    e_adr[m_n] = m_a[ADDR_W+1:2];
                    e_din[m_n] = bus.ldr_wdata;
                    e_wi[m_n]  = m_a[29] ? 4'hf : 4'h0;
                    e_wd[m_n]  = m_a[28] ? 4'hf : 4'h0;
                    e_ld[m_n]  = 1'b1;
                    if (m_a[28]) ref_mem[m_w] = bus.ldr_wdata;
                    free_at = cyc + 2;
                end else if (bus.cpu_req) begin
                    if (bus.ldr_req && wcnt < MAX_WAIT) wcnt++;
                    m_a   = bus.cpu_addr;
                    m_ctl = bus.cpu_LdStCtrl;
                    m_rt  = bus.cpu_wdata;
                    m_w   = int'(m_a[ADDR_W+1:2]);
                    if ((int'(m_a[1:0]) % op_size(m_ctl)) != 0) begin
                        e_cd[m_n] = 1'b1;
                        e_ce[m_n] = 1'b1;
                        free_at = cyc + 2;
                    end else if (m_ctl <= 3'd4) begin
                        e_adr[m_n] = m_a[ADDR_W+1:2];
                        e_cd[(cyc + 3) % 8] = 1'b1;
                        e_rs[(cyc + 3) % 8] = 1'b1;
                        e_rv[(cyc + 3) % 8] = ref_load(ref_mem[m_w], m_ctl, m_a[1:0]);
                        free_at = cyc + 4;
                    end else begin
                        ref_store(m_ctl, m_a[1:0], m_rt, m_lanes, m_din);
                        e_adr[m_n] = m_a[ADDR_W+1:2];
                        e_din[m_n] = m_din;
                        e_wi[m_n]  = m_a[29] ? m_lanes : 4'h0;
                        e_wd[m_n]  = m_a[28] ? m_lanes : 4'h0;
                        e_cd[m_n]  = 1'b1;
                        if (m_a[28])
                            for (int k = 0; k < 4; k++)
                                if (m_lanes[k]) ref_mem[m_w][8*k +: 8] = m_din[8*k +: 8];
                        free_at = cyc + 2;
                    end
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic cpu_op(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] rt,
                          output int lat, output logic [31:0] adr, output logic [31:0] din,
                          output logic [3:0] wi, output logic [3:0] wd, output logic err,
                          output logic [31:0] rd);
        bus.cpu_LdStCtrl = ctl; bus.cpu_addr = a; bus.cpu_wdata = rt; bus.cpu_req = 1'b1;
        lat = -1; adr = '0; din = '0; wi = '0; wd = '0; err = 1'b0; rd = '0;
        for (int n = 0; n < 12; n++) begin
            @(negedge Clock);
            if (bus.mem_adr != '0) adr = 32'(bus.mem_adr);
            if ((bus.we_i | bus.we_d) != 4'h0) din = bus.mem_din;
            wi = wi | bus.we_i;
            wd = wd | bus.we_d;
            if (bus.cpu_done) begin
                lat = n; err = bus.cpu_err; rd = bus.cpu_rdata;
                break;
            end
        end
        tick();
        bus.cpu_req = 1'b0;
    endtask

    task automatic new_cpu();
        logic [31:0] a;
        a = '0;
        a[29:28] = 2'($urandom_range(0, 3));
        a[5:2]   = 4'($urandom_range(0, 15));
        a[1:0]   = 2'($urandom_range(0, 3));
        bus.cpu_addr = a; bus.cpu_LdStCtrl = 3'($urandom_range(0, 7));
        bus.cpu_wdata = $urandom(); bus.cpu_req = 1'b1;
    endtask

    task automatic new_ldr();
        logic [31:0] a;
        a = '0;
        a[29:28] = 2'($urandom_range(0, 3));
        a[5:2]   = 4'($urandom_range(0, 15));
        bus.ldr_addr = a; bus.ldr_wdata = $urandom(); bus.ldr_req = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int          lat, ncpu, nd, ns;
        logic [31:0] adr, din, rd;
        logic [3:0]  wi, wd;
        logic        err, got, cd, ld;

        bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_LdStCtrl = '0; bus.cpu_wdata = '0;
        bus.ldr_req = 0; bus.ldr_addr = '0; bus.ldr_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin bram[i] = '0; ref_mem[i] = '0; end
        bram[0] = 32'hdeadbeef; ref_mem[0] = 32'hdeadbeef;

        repeat (3) @(negedge Clock);
        #2 Reset_n = 1'b1;
        tick();

        cpu_op(3'd5, 32'h70000005, 32'hdeadbeef, lat, adr, din, wi, wd, err, rd);
        chk("sb_lat", 32'(lat), 32'd1);
        chk("sb_adr", adr, 32'h1);
        chk("sb_we_i", 32'(wi), 32'h4);
        chk("sb_we_d", 32'(wd), 32'h4);
        chk("sb_din", din, 32'hefefefef);

        cpu_op(3'd0, 32'h10000002, 32'h0, lat, adr, din, wi, wd, err, rd);
        chk("lb_lat", 32'(lat), 32'd3);
        chk("lb_rdata", rd, 32'hffffffbe);
        cpu_op(3'd3, 32'h10000002, 32'h0, lat, adr, din, wi, wd, err, rd);
        chk("lbu_rdata", rd, 32'h000000be);
        cpu_op(3'd4, 32'h10000000, 32'h0, lat, adr, din, wi, wd, err, rd);
        chk("lhu_rdata", rd, 32'h0000dead);
        cpu_op(3'd1, 32'h10000000, 32'h0, lat, adr, din, wi, wd, err, rd);
        chk("lh_rdata", rd, 32'hffffdead);

        cpu_op(3'd6, 32'h10000001, 32'h1234, lat, adr, din, wi, wd, err, rd);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_err", 32'(err), 32'd1);
        chk("sh_mis_we", 32'({wi, wd}), 32'h0);
        cpu_op(3'd2, 32'h10000002, 32'h0, lat, adr, din, wi, wd, err, rd);
        chk("lw_mis_err", 32'(err), 32'd1);
        chk("lw_mis_lat", 32'(lat), 32'd1);

        // both requesters held continuously
        bus.cpu_LdStCtrl = 3'd7; bus.cpu_addr = 32'h10000008; bus.cpu_wdata = 32'h55aa33cc;
        bus.cpu_req = 1'b1;
        bus.ldr_addr = 32'h20000010; bus.ldr_wdata = 32'h12345678; bus.ldr_req = 1'b1;
        ncpu = 0; got = 1'b0; adr = '0; wi = '0; wd = '0;
        for (int n = 0; n < 60; n++) begin
            @(negedge Clock);
            if (bus.cpu_done) ncpu++;
            if (bus.ldr_done) begin
                got = 1'b1; adr = 32'(bus.mem_adr); wi = bus.we_i; wd = bus.we_d;
                break;
            end
        end
        tick();
        bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
        chk("starve_cpu_grants", 32'(ncpu), 32'd8);
        chk("starve_ldr_done", 32'(got), 32'd1);
        chk("ldr_we_i", 32'(wi), 32'hf);
        chk("ldr_we_d", 32'(wd), 32'h0);
        chk("ldr_adr", adr, 32'h4);

        // load then store with cpu_req never dropping
        bus.cpu_LdStCtrl = 3'd2; bus.cpu_addr = 32'h10000000; bus.cpu_req = 1'b1;
        nd = -1; ns = -1; rd = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge Clock);
            if (nd < 0 && bus.cpu_done) nd = k;
            else if (nd >= 0 && bus.we_d != 4'h0) begin ns = k; rd = bus.cpu_rdata; end
            if (ns >= 0 && bus.cpu_done) break;
            if (nd == k) begin
                tick();
                bus.cpu_LdStCtrl = 3'd7; bus.cpu_addr = 32'h10000004; bus.cpu_wdata = 32'hcafef00d;
            end
        end
        tick();
        bus.cpu_req = 1'b0;
        chk("ld_st_gap", 32'(ns - nd), 32'd2);
        chk("ld_st_rdata_held", rd, 32'hdeadbeef);

        // reset in the WAIT cycle of a load
        bus.cpu_LdStCtrl = 3'd0; bus.cpu_addr = 32'h10000003; bus.cpu_req = 1'b1;
        repeat (3) @(negedge Clock);
        #2 Reset_n = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        chk("arst_rdata", bus.cpu_rdata, 32'h0);
        chk("arst_done", 32'({bus.cpu_done, bus.cpu_err, bus.ldr_done}), 32'h0);
        chk("arst_port", 32'(bus.mem_adr) | 32'({bus.we_i, bus.we_d}) | bus.mem_din, 32'h0);
        repeat (2) @(negedge Clock);
        #2 Reset_n = 1'b1;
        tick();
        cpu_op(3'd7, 32'h10000000, 32'h0badf00d, lat, adr, din, wi, wd, err, rd);
        chk("post_rst_sw_lat", 32'(lat), 32'd1);
        chk("post_rst_sw_we_d", 32'(wd), 32'hf);
        chk("post_rst_sw_din", din, 32'h0badf00d);
        cpu_op(3'd2, 32'h10000000, 32'h0, lat, adr, din, wi, wd, err, rd);
        chk("post_rst_lw", rd, 32'h0badf00d);

        // random traffic; last iterations only retire pending requests
        for (int i = 0; i < 620; i++) begin
            @(negedge Clock);
            cd = bus.cpu_done;
            ld = bus.ldr_done;
            tick();
            if (bus.cpu_req) begin
                if (cd) begin
                    if (i < 600 && $urandom_range(0, 3) != 0) new_cpu();
                    else bus.cpu_req = 1'b0;
                end
            end else if (i < 600 && $urandom_range(0, 2) == 0) new_cpu();
            if (bus.ldr_req) begin
                if (ld) begin
                    if (i < 600 && $urandom_range(0, 3) != 0) new_ldr();
                    else bus.ldr_req = 1'b0;
                end
            end else if (i < 600 && $urandom_range(0, 2) == 0) new_ldr();
        end
        chk("rand_cpu_retired", 32'(bus.cpu_req), 32'd0);
        chk("rand_ldr_retired", 32'(bus.ldr_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
